// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the VC-to-destination FIFO round-robin arbiter.
// Holds the FSM state encoding and the default datapath dimensions.
package fifo_rr_arbiter_pkg;

  localparam int unsigned DATA_W   = 12;
  localparam int unsigned UMBRAL_W = 8;
  localparam int unsigned NUM_VC   = 4;
  localparam int unsigned VC_ID_W  = 2;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

endpackage

// File: rtl/fifo_rr_arbiter_rr_priority_sel.sv
// Combinational rotating-priority selector: grants the first requester found
// scanning upward from ptr, wrapping modulo NUM_VC.
module rr_priority_sel
  import fifo_rr_arbiter_pkg::*;
(
  input  logic [NUM_VC-1:0]  req,
  input  logic [VC_ID_W-1:0] ptr,
  output logic [NUM_VC-1:0]  gnt_onehot,
  output logic [VC_ID_W-1:0] gnt_id,
  output logic               any
);

  always_comb begin
    logic [VC_ID_W-1:0] idx;
    logic               found;
    gnt_onehot = '0;
    gnt_id     = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      idx = ptr + VC_ID_W'(i);
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_id          = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Link controller and round-robin arbiter draining four VC FIFOs into one
// destination FIFO, with a fixed two-cycle pop-to-push pipeline.
module fifo_rr_arbiter #(
  parameter int unsigned DATA_W   = fifo_rr_arbiter_pkg::DATA_W,
  parameter int unsigned UMBRAL_W = fifo_rr_arbiter_pkg::UMBRAL_W,
  parameter int unsigned NUM_VC   = fifo_rr_arbiter_pkg::NUM_VC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [UMBRAL_W-1:0]      umbral_bajo_in,
  input  logic [UMBRAL_W-1:0]      umbral_alto_in,
  input  logic [NUM_VC-1:0]        fifo_empty,
  input  logic [NUM_VC-1:0]        fifo_error,
  input  logic [NUM_VC*DATA_W-1:0] fifo_data,
  input  logic                     dest_almost_full,
  input  logic                     dest_full,
  output logic [NUM_VC-1:0]        pop,
  output logic                     push,
  output logic [DATA_W-1:0]        data_out,
  output logic [UMBRAL_W-1:0]      umbral_bajo,
  output logic [UMBRAL_W-1:0]      umbral_alto,
  output logic [2:0]               state,
  output logic                     idle,
  output logic                     error
);
  import fifo_rr_arbiter_pkg::*;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, grant_q, gnt_id;
  logic [NUM_VC-1:0]   req, gnt_onehot;
  logic                any_req, pop_en;
  logic                pop_q, push_q, idle_q, error_q;
  logic [DATA_W-1:0]   data_q, data_sel;
  logic [UMBRAL_W-1:0] bajo_q, alto_q;

  assign req = ~fifo_empty;

  rr_priority_sel u_sel (
    .req        (req),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (any_req)
  );

  assign pop_en   = (state_q == StActive) && !dest_almost_full && any_req;
  assign pop      = pop_en ? gnt_onehot : '0;
  assign data_sel = fifo_data[grant_q*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:  state_d = StInit;
      StInit:   if (!init) state_d = StIdle;
      StIdle: begin
        if (init)                               state_d = StInit;
        else if (any_req && !dest_almost_full)  state_d = StActive;
      end
      StActive: if (!any_req) state_d = StIdle;
      StError:  state_d = StError;
      default:  state_d = StError;
    endcase
    // Error is sticky and overrides every other transition once out of reset.
    if (state_q != StReset && ((|fifo_error) || (push_q && dest_full))) begin
      state_d = StError;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StReset;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      pop_q    <= 1'b0;
      push_q   <= 1'b0;
      data_q   <= '0;
      bajo_q   <= '0;
      alto_q   <= '0;
      idle_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= (state_d == StIdle);
      error_q <= (state_d == StError);
      if (state_q == StInit) begin
        bajo_q <= umbral_bajo_in;
        alto_q <= umbral_alto_in;
      end
      if (pop_en) begin
        rr_ptr_q <= gnt_id + 2'd1;
        grant_q  <= gnt_id;
      end
      // Source data lands one cycle after pop; entering error drops in-flight words.
      if (state_d == StError) begin
        pop_q  <= 1'b0;
        push_q <= 1'b0;
      end else begin
        pop_q  <= pop_en;
        push_q <= pop_q;
        if (pop_q) data_q <= data_sel;
      end
    end
  end

  assign push        = push_q;
  assign data_out    = data_q;
  assign umbral_bajo = bajo_q;
  assign umbral_alto = alto_q;
  assign state       = state_q;
  assign idle        = idle_q;
  assign error       = error_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: queue-backed source FIFOs plus a rule-level model
// of arbitration order, link state and the two-cycle push latency.
module tb_fifo_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, init, dest_almost_full, dest_full, push, idle, error;
  logic [7:0]  umbral_bajo_in, umbral_alto_in, umbral_bajo, umbral_alto;
  logic [3:0]  fifo_empty, fifo_error, pop;
  logic [47:0] fifo_data;
  logic [11:0] data_out;
  logic [2:0]  state;

  fifo_rr_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .umbral_bajo_in   (umbral_bajo_in),
    .umbral_alto_in   (umbral_alto_in),
    .fifo_empty       (fifo_empty),
    .fifo_error       (fifo_error),
    .fifo_data        (fifo_data),
    .dest_almost_full (dest_almost_full),
    .dest_full        (dest_full),
    .pop              (pop),
    .push             (push),
    .data_out         (data_out),
    .umbral_bajo      (umbral_bajo),
    .umbral_alto      (umbral_alto),
    .state            (state),
    .idle             (idle),
    .error            (error)
  );

  logic [11:0] vcq [4][$];
  logic [11:0] dout [4];
  int checks = 0;
  int passes = 0;

  // Reference model: state as an integer, pipeline as two pending slots.
  int          m_state = 0;
  int          m_ptr = 0;
  bit          m_mid_v = 0, m_push_v = 0;
  logic [11:0] m_mid_d = '0, m_push_d = '0;
  logic [7:0]  m_bajo = '0, m_alto = '0;

  logic [3:0]  s_pop, e_pop;
  logic        s_push, e_push, s_idle, e_idle, s_error, e_error;
  logic [11:0] s_data, e_data;
  logic [2:0]  s_state, e_state;
  logic [7:0]  s_bajo, s_alto;

  task automatic refresh();
    for (int n = 0; n < 4; n++) begin
      fifo_empty[n]         = (vcq[n].size() == 0);
      fifo_data[n*12 +: 12] = dout[n];
    end
  endtask

  task automatic load(input int n, input int cnt);
    repeat (cnt) vcq[n].push_back(12'($urandom));
    refresh();
  endtask

  // One clock: sample DUT, form expectations, advance model and sources.
  task automatic cycle();
    int g;
    bit nonempty;
    @(negedge clk);
    s_pop = pop; s_push = push; s_data = data_out; s_state = state;
    s_idle = idle; s_error = error; s_bajo = umbral_bajo; s_alto = umbral_alto;
    e_state = 3'(m_state); e_idle = (m_state == 2); e_error = (m_state == 4);
    e_push = m_push_v; e_data = m_push_d;
    nonempty = 0;
    for (int k = 0; k < 4; k++) if (vcq[k].size() != 0) nonempty = 1;
    g = -1;
    if (m_state == 3 && !dest_almost_full)
      for (int k = 0; k < 4; k++)
        if (g < 0 && vcq[(m_ptr + k) % 4].size() != 0) g = (m_ptr + k) % 4;
    e_pop = (g < 0) ? 4'b0000 : 4'(1 << g);
    @(posedge clk);
    if (!reset) begin
      m_state = 0; m_ptr = 0; m_mid_v = 0; m_push_v = 0; m_bajo = '0; m_alto = '0;
    end else begin
      m_push_v = m_mid_v; m_push_d = m_mid_d;
      m_mid_v = (g >= 0);
      if (g >= 0) begin
        m_mid_d = vcq[g][0];
        m_ptr = (g + 1) % 4;
      end
      if (m_state == 1) begin
        m_bajo = umbral_bajo_in; m_alto = umbral_alto_in;
      end
      if (m_state != 0 && (fifo_error != 0 || (e_push && dest_full))) m_state = 4;
      else begin
        case (m_state)
          0: m_state = 1;
          1: if (!init) m_state = 2;
          2: if (init) m_state = 1; else if (nonempty && !dest_almost_full) m_state = 3;
          3: if (!nonempty) m_state = 2;
          default: ;
        endcase
      end
      if (m_state == 4) begin
        m_mid_v = 0; m_push_v = 0;
      end
    end
    #1;
    for (int n = 0; n < 4; n++)
      if (s_pop[n] && vcq[n].size() > 0) dout[n] = vcq[n].pop_front();
    refresh();
  endtask

  task automatic bring_up();
    for (int n = 0; n < 4; n++) begin
      vcq[n].delete(); dout[n] = '0;
    end
    refresh();
    fifo_error = '0; dest_almost_full = 0; dest_full = 0;
    reset = 0; init = 0; cycle();
    reset = 1; init = 1; cycle(); cycle();
    init = 0; cycle(); cycle();
  endtask

  task automatic test_reset();
    reset = 0; init = 0; umbral_bajo_in = '0; umbral_alto_in = '0;
    fifo_error = '0; dest_almost_full = 0; dest_full = 0;
    for (int n = 0; n < 4; n++) begin
      vcq[n].delete(); dout[n] = '0;
    end
    refresh();
    cycle(); cycle();
    checks++;
    if ({s_state, s_pop, s_push, s_idle, s_error} !== '0)
      $display("FAIL reset_ctrl got state=%0d pop=%b push=%b idle=%b error=%b want all 0",
               s_state, s_pop, s_push, s_idle, s_error);
    else passes++;
    checks++;
    if ({s_data, s_bajo, s_alto} !== '0)
      $display("FAIL reset_data got data=%h bajo=%h alto=%h want 0", s_data, s_bajo, s_alto);
    else passes++;
  endtask

  task automatic test_init();
    int exp_seq[5] = '{0, 1, 1, 1, 2};
    reset = 1; init = 1; umbral_bajo_in = 8'h02; umbral_alto_in = 8'h06;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) init = 0;
      cycle();
      checks++;
      if (s_state !== 3'(exp_seq[i]))
        $display("FAIL init_state step%0d got %0d want %0d", i, s_state, exp_seq[i]);
      else passes++;
      checks++;
      if ({s_pop, s_push, s_error} !== '0)
        $display("FAIL init_quiet step%0d got pop=%b push=%b error=%b want 0",
                 i, s_pop, s_push, s_error);
      else passes++;
    end
    checks++;
    if (s_bajo !== 8'h02 || s_alto !== 8'h06 || s_idle !== 1'b1)
      $display("FAIL init_thresh got bajo=%h alto=%h idle=%b want 02 06 1",
               s_bajo, s_alto, s_idle);
    else passes++;
  endtask

  task automatic test_single_vc();
    logic [11:0] w[3];
    logic [11:0] got[$];
    for (int i = 0; i < 3; i++) begin
      w[i] = 12'($urandom); vcq[0].push_back(w[i]);
    end
    refresh();
    for (int c = 0; c < 10; c++) begin
      cycle();
      checks++;
      if (s_pop !== e_pop) $display("FAIL single_pop c%0d got %b want %b", c, s_pop, e_pop);
      else passes++;
      checks++;
      if (s_push !== e_push) $display("FAIL single_push c%0d got %b want %b", c, s_push, e_push);
      else passes++;
      if (s_push) got.push_back(s_data);
    end
    checks++;
    if (got.size() != 3) $display("FAIL single_count got %0d want 3", got.size());
    else begin
      passes++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== w[i]) $display("FAIL single_data w%0d got %h want %h", i, got[i], w[i]);
        else passes++;
      end
    end
    checks++;
    if (s_state !== 3'd2) $display("FAIL single_end_state got %0d want 2", s_state);
    else passes++;
  endtask

  task automatic test_round_robin();
    logic [3:0]  want_pop[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [11:0] want[5];
    logic [3:0]  pops[$];
    logic [11:0] got[$];
    bring_up();
    for (int n = 0; n < 4; n++) load(n, 2);
    for (int i = 0; i < 5; i++) want[i] = vcq[i % 4][i / 4];
    for (int c = 0; c < 20; c++) begin
      cycle();
      checks++;
      if (s_pop !== e_pop) $display("FAIL rr_model_pop c%0d got %b want %b", c, s_pop, e_pop);
      else passes++;
      if (s_pop != 0) pops.push_back(s_pop);
      if (s_push) got.push_back(s_data);
    end
    checks++;
    if (pops.size() < 5 || got.size() < 5)
      $display("FAIL rr_count got pops=%0d pushes=%0d want >=5", pops.size(), got.size());
    else begin
      passes++;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pops[i] !== want_pop[i] || got[i] !== want[i])
          $display("FAIL rr_seq #%0d got pop=%b data=%h want pop=%b data=%h",
                   i, pops[i], got[i], want_pop[i], want[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_backpressure();
    int pushes_af = 0;
    int total = 0;
    bring_up();
    for (int n = 0; n < 4; n++) load(n, 4);
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (s_pop !== e_pop) $display("FAIL bp_pre_pop c%0d got %b want %b", c, s_pop, e_pop);
      else passes++;
      if (s_push) total++;
    end
    dest_almost_full = 1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (s_pop !== 4'b0000) $display("FAIL bp_pop c%0d got %b want 0000", c, s_pop);
      else passes++;
      if (s_push) begin
        pushes_af++; total++;
      end
    end
    checks++;
    if (pushes_af > 2) $display("FAIL bp_inflight got %0d pushes want <=2", pushes_af);
    else passes++;
    dest_almost_full = 0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      checks++;
      if (s_pop !== e_pop || s_push !== e_push)
        $display("FAIL bp_resume c%0d got pop=%b push=%b want pop=%b push=%b",
                 c, s_pop, s_push, e_pop, e_push);
      else passes++;
      if (e_push) begin
        checks++;
        if (s_data !== e_data) $display("FAIL bp_data c%0d got %h want %h", c, s_data, e_data);
        else passes++;
      end
      if (s_push) total++;
    end
    checks++;
    if (total != 16) $display("FAIL bp_total got %0d pushes want 16", total);
    else passes++;
  endtask

  task automatic test_error();
    bring_up();
    for (int n = 0; n < 4; n++) load(n, 3);
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (s_pop !== e_pop) $display("FAIL err_pre_pop c%0d got %b want %b", c, s_pop, e_pop);
      else passes++;
    end
    fifo_error = 4'b0100;
    cycle();
    fifo_error = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (s_state !== 3'd4 || s_error !== 1'b1 || s_pop !== 4'b0 || s_push !== 1'b0 || s_idle)
        $display("FAIL err_sticky c%0d got state=%0d error=%b pop=%b push=%b want 4 1 0 0",
                 c, s_state, s_error, s_pop, s_push);
      else passes++;
    end
    reset = 0; cycle();
    reset = 1; cycle();
    checks++;
    if (s_state !== 3'd0 || s_error !== 1'b0)
      $display("FAIL err_reset got state=%0d error=%b want 0 0", s_state, s_error);
    else passes++;
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    bring_up();
    load(1, 1);
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (s_pop != 0) seen = 1;
    end
    checks++;
    if (!seen) $display("FAIL mid_pop_timeout got no pop in 10 cycles want one");
    else passes++;
    reset = 0; cycle(); reset = 1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (s_push !== 1'b0 || s_data !== 12'h000)
        $display("FAIL mid_push c%0d got push=%b data=%h want 0 000", c, s_push, s_data);
      else passes++;
    end
    for (int n = 0; n < 4; n++) load(n, 1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (s_pop != 0) begin
        seen = 1;
        checks++;
        if (s_pop !== 4'b0001) $display("FAIL mid_ptr got %b want 0001", s_pop);
        else passes++;
      end
    end
    checks++;
    if (!seen) $display("FAIL mid_ptr_timeout got no pop in 10 cycles want one");
    else passes++;
    repeat (10) cycle();
  endtask

  task automatic test_random();
    bring_up();
    for (int c = 0; c < 330; c++) begin
      if (c < 300 && $urandom_range(0, 2) == 0) begin
        vcq[$urandom_range(0, 3)].push_back(12'($urandom));
        refresh();
      end
      dest_almost_full = (c < 300) && ($urandom_range(0, 4) == 0);
      cycle();
      checks++;
      if (s_pop !== e_pop) $display("FAIL rand_pop c%0d got %b want %b", c, s_pop, e_pop);
      else passes++;
      checks++;
      if (s_push !== e_push) $display("FAIL rand_push c%0d got %b want %b", c, s_push, e_push);
      else passes++;
      if (e_push) begin
        checks++;
        if (s_data !== e_data) $display("FAIL rand_data c%0d got %h want %h", c, s_data, e_data);
        else passes++;
      end
      checks++;
      if (s_state !== e_state || s_idle !== e_idle || s_error !== e_error)
        $display("FAIL rand_state c%0d got %0d/%b/%b want %0d/%b/%b",
                 c, s_state, s_idle, s_error, e_state, e_idle, e_error);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_vc();
    test_round_robin();
    test_backpressure();
    test_error();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Controller and round-robin arbiter that drains four virtual-channel FIFOs into one shared destination FIFO.
- Sequences link bring-up: reset, then threshold configuration, then idle, then active transfer.
- Distributes the programmed umbral_bajo/umbral_alto thresholds to all FIFOs.
- Issues read_enable (pop) to source FIFOs and write_enable (push) to the destination, honouring back-pressure.
- Sits between the VC FIFO bank and the shared downstream FIFO in the PCIE datapath.

Parameters:
- DATA_W, 12, width of one FIFO word.
- UMBRAL_W, 8, width of the threshold registers.
- NUM_VC, 4, number of source FIFOs. Fixed at 4: grant encoding is 2 bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- init  in  1  configuration request.
- umbral_bajo_in  in  UMBRAL_W  low threshold to program.
- umbral_alto_in  in  UMBRAL_W  high threshold to program.
- fifo_empty  in  4  empty flag of VC0..VC3.
- fifo_error  in  4  error flag of VC0..VC3.
- fifo_data  in  4*DATA_W  data_out of VC0..VC3; VCn occupies bits [n*DATA_W +: DATA_W].
- dest_almost_full  in  1  back-pressure from the destination FIFO.
- dest_full  in  1  destination FIFO full.
- pop  out  4  one-hot read_enable to VC0..VC3.
- push  out  1  write_enable to the destination FIFO.
- data_out  out  DATA_W  word written to the destination FIFO.
- umbral_bajo  out  UMBRAL_W  programmed low threshold, broadcast to all FIFOs.
- umbral_alto  out  UMBRAL_W  programmed high threshold, broadcast to all FIFOs.
- state  out  3  current FSM state.
- idle  out  1  high only in IDLE.
- error  out  1  high only in ERROR.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=RESET (0).
  - pop, push, data_out, umbral_bajo, umbral_alto, idle, error all 0.
  - rr_ptr=0; pipeline registers cleared.
  - Applies mid-transfer too; in-flight words are discarded.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET: next cycle goes to INIT unconditionally.
- INIT:
  - Each cycle, umbral_bajo<=umbral_bajo_in and umbral_alto<=umbral_alto_in.
  - Goes to IDLE when init==0. Thresholds hold their last sampled value.
- IDLE:
  - idle=1.
  - init==1 -> INIT (takes priority).
  - Else any fifo_empty bit low and dest_almost_full==0 -> ACTIVE.
- ACTIVE:
  - pop is combinational from registered state and current inputs.
  - Eligible when dest_almost_full==0 and at least one VC is non-empty.
  - grant = first non-empty VC scanning rr_ptr, rr_ptr+1, ... mod 4.
  - pop[grant]=1 for that cycle; rr_ptr <= grant+1 (wraps 3->0).
  - Not eligible: pop=0 and rr_ptr holds.
  - All four VCs empty -> IDLE.
  - init is ignored in ACTIVE.
- Datapath latency:
  - FIFO data is valid the cycle after its read_enable.
  - Cycle t: pop. Cycle t+1: grant_q and pop_q registered, fifo_data slice grant_q sampled. Cycle t+2: push=1 and data_out valid.
  - Pop-to-push latency is exactly 2 cycles.
  - The destination almost_full threshold must leave at least 2 free slots, since up to 2 words may be in flight.
  - The pipeline drains regardless of state changes into IDLE. Reset and ERROR cancel it.
- ERROR:
  - Entered from any non-RESET state when any fifo_error bit is 1, or when push==1 and dest_full==1 in the same cycle.
  - Sticky until reset.
  - pop=0 and push=0 forced; error=1.
- A pop is never issued to a VC whose fifo_empty is 1.

Decomposition:
- Shared package: state encodings (RESET/INIT/IDLE/ACTIVE/ERROR), DATA_W, UMBRAL_W, NUM_VC.
- One natural sub-module: rr_priority_sel.
  - Purely combinational.
  - Inputs: req[3:0] (~fifo_empty), ptr[1:0].
  - Outputs: gnt_onehot[3:0], gnt_id[1:0], any.

Test Plan:
- Reset then init=1 with 0x02/0x06 for 3 cycles, then init=0 -> state 0,1,1,1,2; umbral_bajo=2, umbral_alto=6; all other outputs 0.
- VC0 only non-empty with 3 words A,B,C, dest free -> pop=0001 for 3 cycles; push high 2 cycles later for 3 cycles; data_out A,B,C; then state IDLE.
- All VCs non-empty, rr_ptr=0 -> pop sequence 0001,0010,0100,1000,0001; data_out follows VC0,VC1,VC2,VC3,VC0.
- Mid-stream dest_almost_full=1 for 4 cycles -> pop=0 the same cycle; at most 2 further pushes; resumes with the next VC in round-robin order, none skipped.
- fifo_error[2]=1 during ACTIVE -> next cycle state=4, error=1, pop=0, push=0; stays until reset==0 returns state to 0.
- reset==0 asserted one cycle after a pop -> no push emitted; data_out=0; rr_ptr=0 after reset.
